// File: rtl/jpu_pkg.sv
// rtl/jpu_pkg.sv - shared JPU datapath types and default widths
//
// Contents:
//   JPU_DATA_WIDTH      default register word width
//   JPU_REG_ADDR_WIDTH  default register address width
//   rf_state_t          register file sequencer state

package jpu_pkg;

  localparam int JPU_DATA_WIDTH     = 16;
  localparam int JPU_REG_ADDR_WIDTH = 3;

  typedef enum logic {
    RF_CLEAR = 1'b0,
    RF_RUN   = 1'b1
  } rf_state_t;

endpackage

// File: rtl/regfile_rd_port.sv
// rtl/regfile_rd_port.sv - one registered read port of the register file
//
// Ports:
//   clock, reset   rising-edge clock, synchronous active-high reset
//   run            high when the register file is out of its clear sequence
//   rd_en          read strobe
//   rd_addr        read address
//   rd_word        current storage content at rd_addr (from the array)
//   wr_en/wr_addr/wr_data  same-cycle write, used for forwarding
//   rd_data        registered read data, 0 when idle, clearing or masked

import jpu_pkg::*;

module regfile_rd_port #(
  parameter int DATA_WIDTH = JPU_DATA_WIDTH,
  parameter int ADDR_WIDTH = JPU_REG_ADDR_WIDTH,
  parameter int ZERO_REG   = 0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  run,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_word,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic                  zero_hit;
  logic                  fwd_hit;
  logic [DATA_WIDTH-1:0] next_data;

  // The hard-wired zero entry wins over forwarding: a write to entry 0 is
  // dropped, so forwarding it would expose a value that never exists.
  assign zero_hit = (ZERO_REG != 0) && (rd_addr == '0);
  assign fwd_hit  = wr_en && (wr_addr == rd_addr);

  always_comb begin
    next_data = '0;
    if (run && rd_en && !zero_hit) begin
      next_data = fwd_hit ? wr_data : rd_word;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_data <= '0;
    end else begin
      rd_data <= next_data;
    end
  end

endmodule

// File: rtl/regfile_2r1w.sv
// rtl/regfile_2r1w.sv - two-read one-write register file with clear sequencer
//
// Ports:
//   clock, reset            rising-edge clock, synchronous active-high reset
//   wr_en/wr_addr/wr_data   write port
//   rd_en_a/rd_addr_a       port A read request, rd_data_a registered result
//   rd_en_b/rd_addr_b       port B read request, rd_data_b registered result
//   ready                   high once every entry has been cleared after reset

import jpu_pkg::*;

module regfile_2r1w #(
  parameter int DATA_WIDTH = JPU_DATA_WIDTH,
  parameter int ADDR_WIDTH = JPU_REG_ADDR_WIDTH,
  parameter int ZERO_REG   = 0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en_a,
  input  logic [ADDR_WIDTH-1:0] rd_addr_a,
  output logic [DATA_WIDTH-1:0] rd_data_a,
  input  logic                  rd_en_b,
  input  logic [ADDR_WIDTH-1:0] rd_addr_b,
  output logic [DATA_WIDTH-1:0] rd_data_b,
  output logic                  ready
);

  localparam int                    DEPTH    = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DEPTH - 1);

  rf_state_t             state;
  logic [ADDR_WIDTH-1:0] clr_idx;
  logic                  ready_q;
  logic                  run;

  // No reset on the array so it can map onto RAM; the sequencer zeroes it.
  logic [DATA_WIDTH-1:0] regs [DEPTH];

  logic                  wr_drop;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_data;

  assign run   = (state == RF_RUN);
  assign ready = ready_q;

  // Clear sequencer. Reset always restarts from entry 0, so a reset that
  // lands mid-clear or mid-run throws away any partially written content.
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= RF_CLEAR;
      clr_idx <= '0;
      ready_q <= 1'b0;
    end else begin
      case (state)
        RF_CLEAR: begin
          clr_idx <= clr_idx + 1'b1;
          if (clr_idx == LAST_IDX) begin
            state   <= RF_RUN;
            ready_q <= 1'b1;
          end
        end
        RF_RUN: begin
          ready_q <= 1'b1;
        end
        default: begin
          state   <= RF_CLEAR;
          clr_idx <= '0;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  // Single write port into the array: the clear path owns it while
  // clearing, the user write path owns it in RUN.
  assign wr_drop = (ZERO_REG != 0) && (wr_addr == '0);

  always_comb begin
    mem_we   = 1'b0;
    mem_addr = '0;
    mem_data = '0;
    if (state == RF_CLEAR) begin
      mem_we   = 1'b1;
      mem_addr = clr_idx;
    end else begin
      mem_we   = wr_en && !wr_drop;
      mem_addr = wr_addr;
      mem_data = wr_data;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && mem_we) begin
      regs[mem_addr] <= mem_data;
    end
  end

  regfile_rd_port #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .ZERO_REG   (ZERO_REG)
  ) u_port_a (
    .clock   (clock),
    .reset   (reset),
    .run     (run),
    .rd_en   (rd_en_a),
    .rd_addr (rd_addr_a),
    .rd_word (regs[rd_addr_a]),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_data (rd_data_a)
  );

  regfile_rd_port #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .ZERO_REG   (ZERO_REG)
  ) u_port_b (
    .clock   (clock),
    .reset   (reset),
    .run     (run),
    .rd_en   (rd_en_b),
    .rd_addr (rd_addr_b),
    .rd_word (regs[rd_addr_b]),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_data (rd_data_b)
  );

endmodule

// File: tb/tb_regfile_2r1w.sv
// tb/tb_regfile_2r1w.sv - scoreboard bench for regfile_2r1w with and without zero register

module tb_regfile_2r1w;

  localparam int DW    = 16;
  localparam int AW    = 3;
  localparam int DEPTH = 8;

  logic          clock = 1'b0;
  logic          reset;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          rd_en_a;
  logic [AW-1:0] rd_addr_a;
  logic          rd_en_b;
  logic [AW-1:0] rd_addr_b;

  logic [DW-1:0] rd_data_a0, rd_data_b0, rd_data_a1, rd_data_b1;
  logic          ready0, ready1;

  always #5 clock = ~clock;

  regfile_2r1w #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ZERO_REG(0)) dut0 (
    .clock(clock), .reset(reset),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en_a(rd_en_a), .rd_addr_a(rd_addr_a), .rd_data_a(rd_data_a0),
    .rd_en_b(rd_en_b), .rd_addr_b(rd_addr_b), .rd_data_b(rd_data_b0),
    .ready(ready0)
  );

  regfile_2r1w #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ZERO_REG(1)) dut1 (
    .clock(clock), .reset(reset),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en_a(rd_en_a), .rd_addr_a(rd_addr_a), .rd_data_a(rd_data_a1),
    .rd_en_b(rd_en_b), .rd_addr_b(rd_addr_b), .rd_data_b(rd_data_b1),
    .ready(ready1)
  );

  typedef struct {
    logic [DW-1:0] a0, b0, a1, b1;
    logic          rdy;
    int            tag;
  } exp_t;

  exp_t          sb[$];
  int            checks = 0;
  int            failures = 0;
  int            ncyc = 0;

  // Reference model: plain word arrays plus a count of clear edges left.
  logic [DW-1:0] mem0 [DEPTH];
  logic [DW-1:0] mem1 [DEPTH];
  int            clear_left = DEPTH;

  function automatic logic [DW-1:0] mread(input bit zr, input logic en, input logic [AW-1:0] addr,
                                          input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd);
    if (!en) return '0;
    if (zr && addr == 0) return '0;
    if (we && wa == addr) return wd;
    return zr ? mem1[addr] : mem0[addr];
  endfunction

  task automatic step(input logic rst, input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                      input logic ea, input logic [AW-1:0] aa, input logic eb, input logic [AW-1:0] ab);
    exp_t e;
    @(negedge clock);
    reset = rst; wr_en = we; wr_addr = wa; wr_data = wd;
    rd_en_a = ea; rd_addr_a = aa; rd_en_b = eb; rd_addr_b = ab;
    e.tag = ncyc;
    ncyc++;
    e.a0 = '0; e.b0 = '0; e.a1 = '0; e.b1 = '0;
    if (rst) begin
      clear_left = DEPTH;
      for (int i = 0; i < DEPTH; i++) begin
        mem0[i] = '0;
        mem1[i] = '0;
      end
      e.rdy = 1'b0;
    end else if (clear_left > 0) begin
      clear_left--;
      e.rdy = (clear_left == 0);
    end else begin
      e.a0 = mread(1'b0, ea, aa, we, wa, wd);
      e.b0 = mread(1'b0, eb, ab, we, wa, wd);
      e.a1 = mread(1'b1, ea, aa, we, wa, wd);
      e.b1 = mread(1'b1, eb, ab, we, wa, wd);
      if (we) begin
        mem0[wa] = wd;
        if (wa != 0) mem1[wa] = wd;
      end
      e.rdy = 1'b1;
    end
    sb.push_back(e);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0, '0);
  endtask

  task automatic chk(input string name, input int tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%h expected=%h", name, tag, act, exp);
    end
  endtask

  // Monitor: every edge the DUTs present a new registered result; compare
  // against whatever the stimulus side queued for that edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("rd_data_a_nozero", e.tag, rd_data_a0, e.a0);
        chk("rd_data_b_nozero", e.tag, rd_data_b0, e.b0);
        chk("rd_data_a_zeroreg", e.tag, rd_data_a1, e.a1);
        chk("rd_data_b_zeroreg", e.tag, rd_data_b1, e.b1);
        chk("ready_nozero", e.tag, {{(DW-1){1'b0}}, ready0}, {{(DW-1){1'b0}}, e.rdy});
        chk("ready_zeroreg", e.tag, {{(DW-1){1'b0}}, ready1}, {{(DW-1){1'b0}}, e.rdy});
      end
    end
  end

  initial begin
    reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rd_en_a = 1'b0; rd_addr_a = '0; rd_en_b = 1'b0; rd_addr_b = '0;

    // Reset, clear sequence, then read every address on both ports.
    step(1'b1, 1'b0, '0, '0, 1'b0, '0, 1'b0, '0);
    step(1'b1, 1'b1, 3'd2, 16'hAAAA, 1'b1, 3'd2, 1'b1, 3'd2);
    for (int i = 0; i < DEPTH; i++) idle();
    for (int i = 0; i < DEPTH; i++)
      step(1'b0, 1'b0, '0, '0, 1'b1, AW'(i), 1'b1, AW'(DEPTH - 1 - i));

    // Write then read the same address on both ports.
    step(1'b0, 1'b1, 3'd5, 16'hBEEF, 1'b0, '0, 1'b0, '0);
    step(1'b0, 1'b0, '0, '0, 1'b1, 3'd5, 1'b1, 3'd5);

    // Same-cycle write/read forwarding; port B reads a neighbour.
    step(1'b0, 1'b1, 3'd3, 16'h0001, 1'b0, '0, 1'b0, '0);
    step(1'b0, 1'b1, 3'd2, 16'h0002, 1'b0, '0, 1'b0, '0);
    step(1'b0, 1'b1, 3'd3, 16'h1234, 1'b1, 3'd3, 1'b1, 3'd2);
    step(1'b0, 1'b0, '0, '0, 1'b1, 3'd3, 1'b1, 3'd3);

    // Entry 0: stored normally without zero register, dropped with it.
    step(1'b0, 1'b1, 3'd0, 16'hFFFF, 1'b1, 3'd0, 1'b1, 3'd0);
    step(1'b0, 1'b0, '0, '0, 1'b1, 3'd0, 1'b1, 3'd0);

    // Read strobe drop returns data to zero.
    step(1'b0, 1'b0, '0, '0, 1'b1, 3'd5, 1'b0, '0);
    step(1'b0, 1'b0, '0, '0, 1'b0, 3'd5, 1'b0, '0);

    // Fill every entry, reset mid-run, write during clear, read all back.
    for (int i = 0; i < DEPTH; i++)
      step(1'b0, 1'b1, AW'(i), DW'(16'hC000 + i), 1'b0, '0, 1'b0, '0);
    step(1'b1, 1'b0, '0, '0, 1'b0, '0, 1'b0, '0);
    step(1'b0, 1'b1, 3'd4, 16'h5A5A, 1'b1, 3'd4, 1'b1, 3'd4);
    for (int i = 0; i < DEPTH - 2; i++) idle();
    step(1'b0, 1'b1, 3'd6, 16'h6666, 1'b1, 3'd6, 1'b0, '0);
    // First RUN edge: strobes presented as ready rises are honoured.
    step(1'b0, 1'b0, '0, '0, 1'b1, 3'd6, 1'b1, 3'd4);
    for (int i = 0; i < DEPTH; i++)
      step(1'b0, 1'b0, '0, '0, 1'b1, AW'(i), 1'b1, AW'(i));

    // Randomised traffic with occasional resets.
    for (int n = 0; n < 600; n++) begin
      step(($urandom_range(0, 79) == 0), 1'($urandom), AW'($urandom), DW'($urandom),
           1'($urandom_range(0, 3) != 0), AW'($urandom), 1'($urandom_range(0, 3) != 0), AW'($urandom));
    end
    idle();

    @(posedge clock);
    #3;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain actual=%0d expected=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
